// File: rtl/moving_average_acc.sv
// Moving-average filter: running sum over the last 2**avg_log2 accepted samples.
// A circular buffer supplies the sample leaving the window (the delayed tap).
// Pipeline: capture/tap read -> accumulate -> registered average output.
module moving_average_acc #(
   parameter int unsigned bus_length = 16,
   parameter int unsigned avg_log2   = 5
) (
   input  logic                         clk_in,
   input  logic                         reset_in,
   input  logic                         clear_in,
   input  logic                         data_in_valid,
   input  logic signed [bus_length-1:0] data_in,
   output logic signed [bus_length-1:0] data_out,
   output logic                         data_out_valid,
   output logic                         filled
);

   localparam int unsigned N  = 1 << avg_log2;
   localparam int unsigned AW = bus_length + avg_log2;
   localparam int unsigned CW = avg_log2 + 1;

   logic signed [bus_length-1:0] r_mem [N];
   logic        [avg_log2-1:0]   r_wptr;
   logic        [CW-1:0]         r_count;
   logic signed [bus_length-1:0] r_x;
   logic signed [bus_length-1:0] r_old;
   logic                         r_old_en;
   logic                         r_v1;
   logic                         r_f1;
   logic signed [AW-1:0]         r_acc;
   logic                         r_v2;
   logic                         r_f2;

   logic                         w_accept;
   logic signed [bus_length-1:0] w_old_masked;
   logic signed [AW-1:0]         w_acc_next;

   // Accepted sample; a coincident clear wins and drops it
   assign w_accept     = data_in_valid & ~clear_in;
   // Tap only contributes once the window has been completely filled
   assign w_old_masked = r_old_en ? r_old : '0;
   assign w_acc_next   = r_acc + AW'(r_x) - AW'(w_old_masked);

   // Circular buffer: read-old-data tap and write of the new sample in one cycle
   always_ff @(posedge clk_in) begin
      if (w_accept) begin
         r_old         <= r_mem[r_wptr];
         r_mem[r_wptr] <= data_in;
      end
   end

   // Stage 1: register sample, advance write pointer, track fill count
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_wptr   <= '0;
         r_count  <= '0;
         r_x      <= '0;
         r_old_en <= 1'b0;
         r_v1     <= 1'b0;
         r_f1     <= 1'b0;
      end else if (clear_in) begin
         r_wptr   <= '0;
         r_count  <= '0;
         r_old_en <= 1'b0;
         r_v1     <= 1'b0;
         r_f1     <= 1'b0;
      end else begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_x      <= data_in;
            r_wptr   <= avg_log2'(r_wptr + 1'b1);
            r_old_en <= (r_count == CW'(N));
            r_f1     <= (r_count >= CW'(N - 1));
            if (r_count != CW'(N)) begin
               r_count <= CW'(r_count + 1'b1);
            end
         end
      end
   end

   // Stage 2: running sum update
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_acc <= '0;
         r_v2  <= 1'b0;
         r_f2  <= 1'b0;
      end else if (clear_in) begin
         r_acc <= '0;
         r_v2  <= 1'b0;
         r_f2  <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_acc <= w_acc_next;
            r_f2  <= r_f1;
         end
      end
   end

   // Stage 3: registered average (floor division by arithmetic shift) and status
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         filled         <= 1'b0;
      end else if (clear_in) begin
         data_out_valid <= 1'b0;
         filled         <= 1'b0;
      end else begin
         data_out_valid <= r_v2;
         if (r_v2) begin
            data_out <= bus_length'(r_acc >>> avg_log2);
            if (r_f2) begin
               filled <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_moving_average_acc.sv
// Bench for moving_average_acc: window-sum reference model plus directed cases.
module tb_moving_average_acc;

   localparam int W = 16;
   localparam int L = 5;
   localparam int N = 32;

   logic                clk_in = 1'b0;
   logic                reset_in = 1'b0;
   logic                clear_in = 1'b0;
   logic                data_in_valid = 1'b0;
   logic signed [W-1:0] data_in = '0;
   logic signed [W-1:0] data_out;
   logic                data_out_valid;
   logic                filled;

   moving_average_acc #(.bus_length(W), .avg_log2(L)) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .clear_in       (clear_in),
      .data_in_valid  (data_in_valid),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .filled         (filled)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int floor_div(input longint s, input longint d);
      longint q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return int'(q);
   endfunction

   // Reference model: window of accepted samples, 2-cycle output delay
   int     win [$];
   longint m_total = 0;
   bit     p1v = 0, p2v = 0, p1f = 0, p2f = 0;
   int     p1a = 0, p2a = 0;
   int     m_out = 0;
   bit     m_vout = 0, m_filled = 0;

   always @(posedge clk_in or posedge reset_in) begin
      longint sum;
      if (reset_in) begin
         win.delete(); m_total = 0;
         p1v = 0; p2v = 0; m_vout = 0; m_filled = 0; m_out = 0;
      end else if (clear_in) begin
         win.delete(); m_total = 0;
         p1v = 0; p2v = 0; m_vout = 0; m_filled = 0;
      end else begin
         m_vout = p2v;
         if (p2v) begin
            m_out = p2a;
            if (p2f) m_filled = 1;
         end
         p2v = p1v; p2a = p1a; p2f = p1f;
         p1v = data_in_valid;
         if (data_in_valid) begin
            win.push_back(int'(data_in));
            if (win.size() > N) void'(win.pop_front());
            m_total++;
            sum = 0;
            foreach (win[i]) sum += win[i];
            p1a = floor_div(sum, N);
            p1f = (m_total >= N);
         end
      end
   end

   // Cycle stamps of accepted inputs and emitted outputs
   int cyc = 0;
   int acc_stamp [$];
   int out_stamp [$];
   int out_log [$];

   always @(posedge clk_in) begin
      cyc++;
      if (!reset_in && !clear_in && data_in_valid) acc_stamp.push_back(cyc);
   end

   // Per-cycle compare against the model, plus output logging
   always @(negedge clk_in) begin
      chk("valid", longint'(data_out_valid), longint'(m_vout));
      chk("filled", longint'(filled), longint'(m_filled));
      chk("data_out", longint'(data_out), longint'(m_out));
      if (data_out_valid) begin
         out_log.push_back(int'(data_out));
         out_stamp.push_back(cyc);
      end
   end

   task automatic send(input int v);
      @(negedge clk_in);
      data_in_valid = 1'b1;
      data_in = W'(v);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         data_in_valid = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk_in);
      data_in_valid = 1'b0;
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int b, b2, sb, n100;
      #1 reset_in = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("reset_out", longint'(data_out), 0);
      chk("reset_valid", longint'(data_out_valid), 0);
      reset_in = 1'b0;

      // Case 1: constant 1000 ramp
      b = out_log.size();
      repeat (40) send(1000);
      idle(4);
      chk("t1_count", out_log.size() - b, 40);
      chk("t1_first", out_log[b], 31);
      chk("t1_second", out_log[b+1], 62);
      chk("t1_31st", out_log[b+30], 968);
      chk("t1_32nd", out_log[b+31], 1000);
      chk("t1_last", out_log[b+39], 1000);
      chk("t1_filled", longint'(filled), 1);

      // Case 2: negative full scale then positive full scale
      do_clear();
      chk("t2_filled_clr", longint'(filled), 0);
      b = out_log.size();
      repeat (32) send(-32768);
      repeat (32) send(32767);
      idle(4);
      chk("t2_first", out_log[b], -1024);
      chk("t2_negfull", out_log[b+31], -32768);
      chk("t2_step", out_log[b+32], -30721);
      chk("t2_posfull", out_log[b+63], 32767);

      // Case 3: impulse exercises pointer wrap
      do_clear();
      b = out_log.size();
      repeat (32) send(0);
      send(3200);
      repeat (40) send(0);
      idle(4);
      n100 = 0;
      for (int i = b; i < out_log.size(); i++) if (out_log[i] == 100) n100++;
      chk("t3_n100", n100, 32);
      chk("t3_before", out_log[b+31], 0);
      chk("t3_hit", out_log[b+32], 100);
      chk("t3_after", out_log[b+64], 0);

      // Case 4: sparse valids, latency exactly two cycles
      do_clear();
      b = out_log.size();
      sb = acc_stamp.size();
      repeat (40) begin
         send(64);
         idle(2);
      end
      idle(4);
      chk("t4_count", out_log.size() - b, 40);
      for (int k = 0; k < 40; k++) begin
         chk("t4_val", out_log[b+k], 2 * ((k + 1 < 32) ? k + 1 : 32));
         chk("t4_lat", out_stamp[b+k] - acc_stamp[sb+k], 2);
      end

      // Case 5: clear with coincident valid drops that sample
      do_clear();
      b = out_log.size();
      repeat (20) send(500);
      idle(4);
      @(negedge clk_in);
      data_in_valid = 1'b1; data_in = W'(500); clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
      chk("t5_filled_clr", longint'(filled), 0);
      data_in_valid = 1'b1; data_in = W'(500);
      idle(4);
      chk("t5_count", out_log.size() - b, 21);
      chk("t5_20th", out_log[b+19], 312);
      chk("t5_after", out_log[b+20], 15);

      // Case 6: asynchronous reset mid-stream
      do_clear();
      repeat (10) send(1000);
      @(posedge clk_in);
      #2 reset_in = 1'b1;
      #1;
      chk("t6_rst_out", longint'(data_out), 0);
      chk("t6_rst_valid", longint'(data_out_valid), 0);
      chk("t6_rst_filled", longint'(filled), 0);
      @(negedge clk_in);
      data_in_valid = 1'b0;
      repeat (2) @(posedge clk_in);
      #3 reset_in = 1'b0;
      b2 = out_log.size();
      idle(4);
      chk("t6_no_spurious", out_log.size() - b2, 0);
      repeat (40) send(1000);
      idle(4);
      chk("t6_first", out_log[b2], 31);
      chk("t6_32nd", out_log[b2+31], 1000);
      chk("t6_filled", longint'(filled), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
